// File: rtl/mac_acc_negator_pipe_if.sv
// Beat interface for the MAC accumulator negator: the input side carries the
// config, lane data and sign flags, and the output side carries the result lanes.
interface mac_acc_negator_pipe_if #(
  parameter int NUM_LANES  = 4,
  parameter int LANE_WIDTH = 32,
  parameter int CONF_WIDTH = 4
);
  logic                              in_valid;
  logic                              in_ready;
  logic [CONF_WIDTH-1:0]             cfg;
  logic [NUM_LANES*LANE_WIDTH-1:0]   in_data;
  logic [NUM_LANES-1:0]              in_neg;
  logic                              out_valid;
  logic                              out_ready;
  logic [NUM_LANES*LANE_WIDTH-1:0]   out_data;
  logic [NUM_LANES-1:0]              out_neg;

  modport master (
    output in_valid, cfg, in_data, in_neg, out_ready,
    input  in_ready, out_valid, out_data, out_neg
  );

  modport slave (
    input  in_valid, cfg, in_data, in_neg, out_ready,
    output in_ready, out_valid, out_data, out_neg
  );
endinterface

// File: rtl/mac_acc_negator_pipe.sv
// Two-stage conditional two's-complement negator for grouped MAC accumulator lanes.
// S1 registers the raw beat; the carry chain and negation are computed from S1 and registered into S2.
module mac_acc_negator_pipe #(
  parameter int NUM_LANES  = 4,
  parameter int LANE_WIDTH = 32,
  parameter int MODE_WIDTH = 2,
  parameter int CONF_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mac_acc_negator_pipe_if.slave  bus
);

  localparam int DATA_W     = NUM_LANES * LANE_WIDTH;
  localparam int LOG2_LANES = $clog2(NUM_LANES);

  typedef struct packed {
    logic [CONF_WIDTH-1:0] cfg;
    logic [DATA_W-1:0]     data;
    logic [NUM_LANES-1:0]  neg;
  } beat_t;

  logic                  s1_valid_q, s1_valid_d;
  beat_t                 s1_beat_q,  s1_beat_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0]     s2_data_q,  s2_data_d;
  logic [NUM_LANES-1:0]  s2_neg_q,   s2_neg_d;

  logic                  adv1, adv2;
  logic                  signed_en;
  logic [MODE_WIDTH-1:0] mode;
  logic [LANE_WIDTH-1:0] lane_x;
  logic [NUM_LANES-1:0]  grp_low, lane_zero, cin, lane_sel;
  logic [DATA_W-1:0]     neg_data;

  assign adv2 = ~s2_valid_q | bus.out_ready;
  assign adv1 = ~s1_valid_q | adv2;

  assign bus.in_ready  = adv1;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign bus.out_neg   = s2_neg_q;

  // Group decode, ripple carry chain and conditional negate, all from the S1 beat.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
    signed_en = s1_beat_q.cfg[CONF_WIDTH-1];
    mode      = s1_beat_q.cfg[MODE_WIDTH-1:0];
    lane_x    = '0;
    grp_low   = '0;
    lane_zero = '0;
    lane_sel  = '0;
    cin       = '0;
    neg_data  = '0;

    for (int j = 0; j < NUM_LANES; j++) begin
      lane_x       = s1_beat_q.data[j*LANE_WIDTH +: LANE_WIDTH];
      lane_zero[j] = (lane_x == '0);
      // Out-of-range modes and mode 0 both fall back to single-lane groups.
      grp_low[j]   = 1'b1;
      lane_sel[j]  = signed_en & s1_beat_q.neg[j];
      for (int g = 1; g <= LOG2_LANES; g++) begin
        if (int'(mode) == g) begin
          grp_low[j]  = ((j % (1 << g)) == 0);
          lane_sel[j] = signed_en & s1_beat_q.neg[(j / (1 << g)) * (1 << g) + (1 << g) - 1];
        end
      end
    end

    // A group's lowest lane restarts the chain, which kills carry from the group below.
    cin[0] = 1'b1;
    for (int j = 1; j < NUM_LANES; j++) begin
      cin[j] = grp_low[j] | (cin[j-1] & lane_zero[j-1]);
    end

    for (int j = 0; j < NUM_LANES; j++) begin
      lane_x = s1_beat_q.data[j*LANE_WIDTH +: LANE_WIDTH];
      neg_data[j*LANE_WIDTH +: LANE_WIDTH] =
        lane_sel[j] ? (~lane_x + {{(LANE_WIDTH-1){1'b0}}, cin[j]}) : lane_x;
    end
  end

  // Pipeline advance: each stage loads when it is empty or its content moves on.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_beat_d  = s1_beat_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_neg_d   = s2_neg_q;

    if (adv1) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_beat_d = '{cfg: bus.cfg, data: bus.in_data, neg: bus.in_neg};
      end
    end

    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = neg_data;
        s2_neg_d  = lane_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset too, so out_data/out_neg read 0 during and after reset.
      s1_valid_q <= 1'b0;
      s1_beat_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_neg_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values.
      s1_valid_q <= s1_valid_d;
      s1_beat_q  <= s1_beat_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_neg_q   <= s2_neg_d;
    end
  end

endmodule

// File: tb/tb_mac_acc_negator_pipe.sv
// Randomised and directed bench for mac_acc_negator_pipe with a wide-word arithmetic reference
// model and an in-order scoreboard.
module tb_mac_acc_negator_pipe;

  localparam int NL = 4;
  localparam int LW = 32;
  localparam int MW = 2;
  localparam int CW = 4;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   neg;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  exp_t exp_q[$];
  exp_t mon_e;

  mac_acc_negator_pipe_if #(.NUM_LANES(NL), .LANE_WIDTH(LW), .CONF_WIDTH(CW)) bus ();

  mac_acc_negator_pipe #(
    .NUM_LANES(NL), .LANE_WIDTH(LW), .MODE_WIDTH(MW), .CONF_WIDTH(CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Reference: treat each group as one wide integer and negate it modulo 2^(G*32).
  function automatic exp_t model(input logic [3:0] c, input logic [127:0] d, input logic [3:0] n);
    exp_t         r;
    int           m;
    int           g;
    logic [127:0] mask;
    logic [127:0] word;
    m = int'(c[1:0]);
    g = (m > 2) ? 1 : (1 << m);
    mask = (g == 4) ? {128{1'b1}} : ((128'd1 << (g * 32)) - 128'd1);
    r.data = '0;
    r.neg  = '0;
    for (int k = 0; k < 4 / g; k++) begin
      word = (d >> (k * g * 32)) & mask;
      if (c[3] && ((n >> (k * g + g - 1)) & 4'd1) != 4'd0) begin
        word  = (128'd0 - word) & mask;
        r.neg = r.neg | (4'((1 << g) - 1) << (k * g));
      end
      r.data = r.data | (word << (k * g * 32));
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_lane();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard: accepted beats are modelled, emitted beats must match them in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: got data=%h neg=%b, expected no beat", bus.out_data, bus.out_neg);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.out_data !== mon_e.data || bus.out_neg !== mon_e.neg) begin
            errors++;
            $display("FAIL sb_beat: got data=%h neg=%b, expected data=%h neg=%b",
                     bus.out_data, bus.out_neg, mon_e.data, mon_e.neg);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.cfg, bus.in_data, bus.in_neg));
      end
    end
  end

  // Present a beat from posedge+1 and hold it until it is accepted; reports cycles taken.
  task automatic push_beat(input logic [3:0] c, input logic [127:0] d, input logic [3:0] n,
                           output int waited);
    bit acc;
    acc         = 1'b0;
    waited      = 0;
    bus.in_valid = 1'b1;
    bus.cfg      = c;
    bus.in_data  = d;
    bus.in_neg   = n;
    while (!acc && waited < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles, expected acceptance", waited);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d beats still pending, expected 0", name, exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Single beat into an idle pipe: checks 2-cycle latency and the exact result.
  task automatic run_directed(input string name, input logic [3:0] c, input logic [127:0] d,
                              input logic [3:0] n, input logic [127:0] exp_d, input logic [3:0] exp_n);
    int w;
    push_beat(c, d, n, w);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_lat1: out_valid=%b one cycle after transfer, expected 0", name, bus.out_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d || bus.out_neg !== exp_n) begin
      errors++;
      $display("FAIL %s_out: valid=%b data=%h neg=%b, expected valid=1 data=%h neg=%b",
               name, bus.out_valid, bus.out_data, bus.out_neg, exp_d, exp_n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.cfg       = '0;
    bus.in_data   = '0;
    bus.in_neg    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_neg !== '0) begin
      errors++;
      $display("FAIL reset_out: valid=%b data=%h neg=%b, expected all 0",
               bus.out_valid, bus.out_data, bus.out_neg);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: in_ready=%b, expected 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_modes();
    run_directed("single", 4'b1000, {32'h0, 32'h0, 32'h0, 32'h5}, 4'b0001,
                 {32'h0, 32'h0, 32'h0, 32'hFFFF_FFFB}, 4'b0001);
    run_directed("quad_one", 4'b1010, {32'h0, 32'h0, 32'h0, 32'h1}, 4'b1000,
                 {4{32'hFFFF_FFFF}}, 4'b1111);
    run_directed("quad_zero", 4'b1010, 128'h0, 4'b1000, 128'h0, 4'b1111);
    run_directed("quad_lowflags", 4'b1010, {32'h1, 32'h2, 32'h3, 32'h4}, 4'b0111,
                 {32'h1, 32'h2, 32'h3, 32'h4}, 4'b0000);
    run_directed("dual", 4'b1001, {32'h0, 32'h7, 32'h1, 32'h0}, 4'b1010,
                 {32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'h0}, 4'b1111);
    run_directed("unsigned", 4'b0010, {32'hDEAD_BEEF, 32'h0, 32'h1, 32'h8000_0000}, 4'b1111,
                 {32'hDEAD_BEEF, 32'h0, 32'h1, 32'h8000_0000}, 4'b0000);
    run_directed("mode3_single", 4'b1011, {32'h0, 32'h2, 32'h0, 32'h8000_0000}, 4'b0101,
                 {32'h0, 32'hFFFF_FFFE, 32'h0, 32'h8000_0000}, 4'b0101);
    drain("modes");
  endtask

  task automatic test_back_to_back();
    logic [3:0] cfgs [4];
    int         w;
    cfgs[0] = 4'b1010;
    cfgs[1] = 4'b1001;
    cfgs[2] = 4'b1000;
    cfgs[3] = 4'b0011;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_beat(cfgs[i], {rand_lane(), rand_lane(), rand_lane(), rand_lane()}, 4'($urandom), w);
      checks++;
      if (w != 1) begin
        errors++;
        $display("FAIL b2b_bubble: beat %0d took %0d cycles, expected 1", i, w);
      end
    end
    drain("b2b");
  endtask

  task automatic test_backpressure();
    logic [127:0] hold_d;
    logic [3:0]   hold_n;
    int           w;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          push_beat(4'($urandom), {rand_lane(), rand_lane(), rand_lane(), rand_lane()},
                    4'($urandom), w);
        end
      end
      begin
        repeat (3) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_full: in_ready=%b out_valid=%b, expected 0 and 1",
                   bus.in_ready, bus.out_valid);
        end
        hold_d = bus.out_data;
        hold_n = bus.out_neg;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_data !== hold_d || bus.out_neg !== hold_n) begin
          errors++;
          $display("FAIL bp_stable: in_ready=%b data=%h neg=%b, expected 0 data=%h neg=%b",
                   bus.in_ready, bus.out_data, bus.out_neg, hold_d, hold_n);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain("bp");
  endtask

  task automatic test_random();
    bit done;
    int w;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          push_beat(4'($urandom), {rand_lane(), rand_lane(), rand_lane(), rand_lane()},
                    4'($urandom), w);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain("random");
  endtask

  task automatic test_reset_midstream();
    int w;
    bus.out_ready = 1'b0;
    push_beat(4'b1000, {4{32'h1234_5678}}, 4'b1111, w);
    push_beat(4'b1010, {4{32'h0000_0001}}, 4'b1000, w);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_neg !== '0) begin
      errors++;
      $display("FAIL midrst_async: valid=%b data=%h neg=%b, expected all 0",
               bus.out_valid, bus.out_data, bus.out_neg);
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    run_directed("midrst_new", 4'b1001, {32'h0, 32'h0, 32'h0, 32'h3}, 4'b0010,
                 {32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD}, 4'b0011);
    drain("midrst");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
